// File: rtl/mips_cpu.sv
// Multicycle 16-bit MIPS-style core sharing one external SRAM for code and data.
// FETCH/DECODE/EXEC/MEM sequencing; bus outputs are registered so the write strobe never glitches.
module mips_cpu #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16,
   parameter int NREG   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   output logic              SRAMWEn,
   output logic [ADDR_W-1:0] SRAMaddress,
   inout  wire  [DATA_W-1:0] SRAMdata
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED} state_t;

   state_t              state, state_n;
   logic                bank;
   logic [DATA_W-1:0]   pc, pc_n, ir;
   logic [DATA_W-1:0]   res, res_q, wd_q;
   logic                taken, taken_q;
   logic [ADDR_W-1:0]   addr_n;
   logic                wen_n;
   logic [DATA_W-1:0]   rf [NREG];

   logic [3:0]          op;
   logic [2:0]          rs, rt, rd, fn;
   logic [DATA_W-1:0]   imm, rs_v, rt_v;

   assign op   = ir[15:12];
   assign rs   = ir[11:9];
   assign rt   = ir[8:6];
   assign rd   = ir[5:3];
   assign fn   = ir[2:0];
   assign imm  = {{(DATA_W-6){ir[5]}}, ir[5:0]};
   assign rs_v = rf[rs];
   assign rt_v = rf[rt];

   // core drives the shared bus only during the single write cycle
   assign SRAMdata = SRAMWEn ? {DATA_W{1'bz}} : wd_q;

   // ALU / effective address / branch resolution, captured at the end of DECODE
   always_comb begin
      res   = rs_v + imm;
      taken = 1'b0;
      case (op)
         4'd0: begin
            case (fn)
               3'd0: res = rs_v + rt_v;
               3'd1: res = rs_v - rt_v;
               3'd2: res = rs_v & rt_v;
               3'd3: res = rs_v | rt_v;
               3'd4: res = rs_v ^ rt_v;
               3'd5: res = {{(DATA_W-1){1'b0}}, ($signed(rs_v) < $signed(rt_v))};
               3'd6: res = rs_v << rt_v[3:0];
               default: res = rs_v >> rt_v[3:0];
            endcase
         end
         4'd4: begin
            res   = pc + imm;
            taken = (rs_v == rt_v);
         end
         4'd5: begin
            res   = pc + imm;
            taken = (rs_v != rt_v);
         end
         4'd6: begin
            res   = {{(DATA_W-12){1'b0}}, ir[11:0]};
            taken = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      addr_n  = SRAMaddress;
      wen_n   = 1'b1;
      case (state)
         S_FETCH: begin
            state_n = S_DECODE;
            pc_n    = pc + 1'b1;
         end
         S_DECODE: state_n = S_EXEC;
         S_EXEC: begin
            state_n = S_FETCH;
            case (op)
               4'd2, 4'd3: begin
                  state_n = S_MEM;
                  addr_n  = {bank, 1'b0, res_q};
                  wen_n   = (op != 4'd3);
               end
               4'd4, 4'd5, 4'd6: if (taken_q) pc_n = res_q;
               4'hF: state_n = S_HALTED;
               default: ;
            endcase
            if (state_n == S_FETCH) addr_n = {bank, 1'b0, pc_n};
         end
         S_MEM: begin
            state_n = S_FETCH;
            addr_n  = {bank, 1'b0, pc};
         end
         default: state_n = S_HALTED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_FETCH;
         pc          <= '0;
         bank        <= sel;
         SRAMaddress <= {sel, 1'b0, {DATA_W{1'b0}}};
         SRAMWEn     <= 1'b1;
         ir          <= '0;
         res_q       <= '0;
         wd_q        <= '0;
         taken_q     <= 1'b0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         SRAMaddress <= addr_n;
         SRAMWEn     <= wen_n;
         if (state == S_FETCH) ir <= SRAMdata;
         if (state == S_DECODE) begin
            res_q   <= res;
            taken_q <= taken;
            wd_q    <= rt_v;
         end
         // R0 is never written, so reads of it stay zero
         if (state == S_EXEC && op == 4'd0 && rd != 3'd0) rf[rd] <= res_q;
         if (state == S_EXEC && op == 4'd1 && rt != 3'd0) rf[rt] <= res_q;
         if (state == S_MEM  && op == 4'd2 && rt != 3'd0) rf[rt] <= SRAMdata;
      end
   end

endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: SRAM model on the shared bus, expected stores queued per program
// and matched against every observed write cycle.
module tb_mips_cpu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sel = 1'b1;
   logic        SRAMWEn;
   logic [17:0] SRAMaddress;
   wire  [15:0] bus;

   logic [15:0] mem [0:262143];

   typedef struct {
      logic [17:0] addr;
      logic [15:0] data;
      int          cyc;
   } wr_t;

   wr_t sb[$];
   wr_t mon_e;
   int  vecs = 0;
   int  errs = 0;
   int  cyc  = 0;
   int  wen_low = 0;

   always #5 clk = ~clk;

   mips_cpu dut (
      .clk(clk), .rst(rst), .sel(sel),
      .SRAMWEn(SRAMWEn), .SRAMaddress(SRAMaddress), .SRAMdata(bus)
   );

   assign bus = SRAMWEn ? mem[SRAMaddress] : 16'hzzzz;

   always @(posedge clk) begin
      if (!SRAMWEn) mem[SRAMaddress] <= bus;
      cyc <= rst ? cyc + 1 : 0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic exp_wr(input logic [17:0] a, input logic [15:0] d, input int c);
      wr_t e;
      e.addr = a;
      e.data = d;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   function automatic logic [15:0] enc_i(input int op, input int rs, input int rt, input int imm);
      return {op[3:0], rs[2:0], rt[2:0], imm[5:0]};
   endfunction

   function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int f);
      return {4'd0, rs[2:0], rt[2:0], rd[2:0], f[2:0]};
   endfunction

   function automatic logic [15:0] enc_j(input int t);
      return {4'd6, t[11:0]};
   endfunction

   // every write cycle must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst && !SRAMWEn) begin
         wen_low++;
         if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
         else begin
            mon_e = sb.pop_front();
            chk("wr_addr", {14'd0, SRAMaddress}, {14'd0, mon_e.addr});
            chk("wr_data", {16'd0, bus}, {16'd0, mon_e.data});
            if (mon_e.cyc >= 0) chk("wr_cyc", cyc, mon_e.cyc);
         end
      end
   end

   task automatic do_reset(input logic s, input int n);
      @(negedge clk);
      rst = 1'b0;
      sel = s;
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic halt_idle(input string tag);
      logic [17:0] a;
      int          chg;
      a   = SRAMaddress;
      chg = 0;
      repeat (10) begin
         @(negedge clk);
         if (SRAMaddress !== a || SRAMWEn !== 1'b1) chg++;
      end
      chk(tag, chg, 0);
   endtask

   initial begin
      logic [15:0] pb [$];
      for (int k = 0; k < 64; k++) begin
         mem[18'h00000 + k] <= 16'h0;
         mem[18'h20000 + k] <= 16'h0;
      end
      #1;

      // bank 1: ADDI/ADDI/ADD/SW/HALT
      mem[18'h20000] <= enc_i(1, 0, 1, 5);
      mem[18'h20001] <= enc_i(1, 0, 2, -3);
      mem[18'h20002] <= enc_r(1, 2, 3, 0);
      mem[18'h20003] <= enc_i(3, 0, 3, 16);
      mem[18'h20004] <= 16'hF000;
      exp_wr(18'h20010, 16'h0002, 12);

      do_reset(1'b1, 3);
      chk("rst_addr_b1", {14'd0, SRAMaddress}, 32'h20000);
      chk("rst_wen", {31'd0, SRAMWEn}, 1);
      rst = 1'b1;
      wen_low = 0;
      repeat (13) @(negedge clk);
      chk("halt_fetch_addr", {14'd0, SRAMaddress}, 32'h20004);
      repeat (30) @(negedge clk);
      chk("wen_pulses", wen_low, 1);
      chk("mem_20010", {16'd0, mem[18'h20010]}, 32'h0002);
      chk("sb_empty_1", sb.size(), 0);
      halt_idle("halt_idle_1");

      // bank 1: LW/SW, jump over the data area, then loop and ALU coverage
      mem[18'h20000] <= enc_i(2, 0, 4, 16);
      mem[18'h20001] <= enc_i(3, 0, 4, 17);
      mem[18'h20002] <= enc_j(16'h20);
      pb = '{enc_i(1, 0, 1, 3), enc_i(1, 1, 1, -1), enc_i(5, 1, 0, -2), enc_i(3, 0, 1, 18),
             enc_i(1, 0, 0, 7), enc_i(3, 0, 0, 19), enc_i(1, 0, 1, -1), enc_i(1, 0, 2, 1),
             enc_r(1, 2, 3, 5), enc_i(3, 0, 3, 20), enc_r(2, 1, 5, 1), enc_i(3, 0, 5, 21),
             enc_r(1, 2, 6, 6), enc_i(3, 0, 6, 22), enc_r(1, 2, 7, 7), enc_i(3, 0, 7, 23),
             enc_r(1, 2, 3, 4), enc_i(3, 0, 3, 24), enc_i(4, 0, 0, 1), enc_i(3, 0, 1, 31),
             enc_j(16'h36), enc_i(3, 0, 1, 30), 16'h7000, enc_r(1, 2, 3, 3),
             enc_i(3, 0, 3, 25), enc_r(1, 2, 3, 2), enc_i(3, 0, 3, 26), 16'hF000};
      foreach (pb[k]) mem[18'h20020 + k] <= pb[k];
      exp_wr(18'h20011, 16'h0002, 7);
      exp_wr(18'h20012, 16'h0000, 35);
      exp_wr(18'h20013, 16'h0000, -1);
      exp_wr(18'h20014, 16'h0001, -1);
      exp_wr(18'h20015, 16'h0002, -1);
      exp_wr(18'h20016, 16'hFFFE, -1);
      exp_wr(18'h20017, 16'h7FFF, -1);
      exp_wr(18'h20018, 16'hFFFE, -1);
      exp_wr(18'h20019, 16'hFFFF, -1);
      exp_wr(18'h2001A, 16'h0001, -1);

      do_reset(1'b1, 2);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      sel = 1'b0;
      repeat (180) @(negedge clk);
      chk("sb_empty_2", sb.size(), 0);
      chk("mem_20011", {16'd0, mem[18'h20011]}, 32'h0002);
      halt_idle("halt_idle_2");

      // bank 0: registers must come back cleared after reset
      mem[18'h00000] <= enc_i(1, 0, 1, 9);
      mem[18'h00001] <= enc_i(3, 0, 1, 16);
      mem[18'h00002] <= enc_i(3, 0, 4, 17);
      mem[18'h00003] <= 16'hF000;
      exp_wr(18'h00010, 16'h0009, 6);
      exp_wr(18'h00011, 16'h0000, 10);

      do_reset(1'b0, 3);
      chk("rst_addr_b0", {14'd0, SRAMaddress}, 32'h00000);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("sb_empty_3", sb.size(), 0);
      chk("mem_00010", {16'd0, mem[18'h00010]}, 32'h0009);
      chk("b1_kept_20010", {16'd0, mem[18'h20010]}, 32'h0002);
      chk("b1_kept_20011", {16'd0, mem[18'h20011]}, 32'h0002);
      chk("b1_skip_2001F", {16'd0, mem[18'h2001F]}, 32'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/mips_cpu.md
Name: mips_cpu

Overview:
- Compact multicycle 16-bit MIPS-style processor. It fetches instructions from, and loads/stores data to, one external 16-bit single-port SRAM over a shared bus.
- Instructions and data share the SRAM; there are no internal memories besides the register file.
- `sel`, sampled during reset, picks one of two 64K-word SRAM banks. The same core can therefore boot two different programs.
- Top-level integrates the core and the SRAM model.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 16, SRAM data, instruction and register width.
- NREG, 8, number of general registers (R0 hardwired to 0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset.
- sel  input  1  bank select; latched every cycle while rst=0, ignored while rst=1.
- SRAMWEn  output  1  SRAM write enable, active-low; SRAM writes `SRAMdata` to `SRAMaddress` on the rising edge while low.
- SRAMaddress  output  18  word address = {bank, 1'b0, addr16}, where bank is the latched sel.
- SRAMdata  inout  16  driven by the core only while SRAMWEn=0, else high-Z. The SRAM drives it combinationally with mem[address] while SRAMWEn=1.

Behaviour:
- Reset (rst=0 at a clock edge):
  - PC=0; all registers=0; state=FETCH; SRAMWEn=1; SRAMdata released.
  - bank<=sel; SRAMaddress={sel,1'b0,16'h0000}.
- Instruction format (16-bit):
  - op[15:12], rs[11:9], rt[8:6], rd[5:3], funct[2:0].
  - imm6[5:0], sign-extended to 16 bits.
  - J-type target = instr[11:0], zero-extended.
- Opcodes:
  - 0 R-type, funct: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1/0), 6 SLL rd=rs<<rt[3:0], 7 SRL (logical).
  - 1 ADDI rt=rs+imm.
  - 2 LW rt=mem[rs+imm].
  - 3 SW mem[rs+imm]=rt.
  - 4 BEQ, 5 BNE: if taken, PC=PC+1+imm.
  - 6 J: PC=target.
  - 15 HALT.
  - All other opcodes are NOP.
- Arithmetic: 16-bit two's complement, wraps silently, no overflow trap. Effective address = (rs+imm) mod 2^16. Writes to R0 are discarded; reads of R0 return 0.
- FSM, one state per cycle:
  - FETCH: SRAMaddress={bank,0,PC}; IR<=SRAMdata at edge; PC<=PC+1.
  - DECODE: read rs/rt; compute ALU result or effective address.
  - EXEC:
    - R/ADDI write back and go to FETCH.
    - BEQ/BNE/J update PC and go to FETCH.
    - LW/SW go to MEM.
    - HALT goes to HALTED.
    - NOP goes to FETCH.
  - MEM:
    - LW: SRAMaddress={bank,0,ea}; rt<=SRAMdata at edge.
    - SW: SRAMWEn=0 for exactly this one cycle; SRAMdata=rt; SRAMaddress={bank,0,ea}.
    - Then go to FETCH.
  - HALTED: SRAMWEn=1; bus idle; stays until reset.
- Latencies:
  - ALU, branch, jump, NOP: 3 cycles per instruction.
  - LW, SW: 4 cycles per instruction.
- SRAMWEn is low only in the MEM state of SW. The address and data are stable for that whole cycle, with no glitch at entry or exit.
- PC wrap: 16'hFFFF+1 → 0, staying in the same bank.
- Reset mid-operation, including mid-SW: reset wins. SRAMWEn=1 on the following cycle; no partial write beyond the already-clocked edge.
- A change of sel while rst=1 has no effect until the next reset.

Test Plan:
- Reset with sel=1 → SRAMaddress=18'h20000, SRAMWEn=1, SRAMdata=Z; first fetch from word 0 of bank 1.
- Bank 1 program ADDI R1,R0,5; ADDI R2,R0,-3; ADD R3,R1,R2; SW R3,0x10(R0); HALT → SRAM[18'h20010]=16'h0002; SRAMWEn low for exactly one cycle; HALTED is reached after 3+3+3+4+3 cycles.
- LW R4,0x10(R0) after the store, then SW R4,0x11(R0) → SRAM[18'h20011]=16'h0002.
- Loop ADDI R1,R1,-1; BNE R1,R0,-2 starting from R1=3 → two taken branches, then fall-through; R1=0 at exit.
- Flip sel to 0 while running, then pulse reset low for ≥2 cycles → execution restarts at 18'h00000 and runs the bank 0 program. Its stores land only in bank 0; bank 1 contents are unchanged.
- Write to R0 (ADDI R0,R0,7) then SW R0 → stored value is 16'h0000. SLT with R1=-1, R2=1 → 1.
